// File: rtl/hiscore_pkg.sv
// hiscore_pkg
// Shared types for the high-score RAM port.
//   HS_ADDR_W / HS_DATA_W : work-RAM address and data widths.
//   hs_wr_t               : one buffered engine write (address + data).
//   hs_grant_e            : owner of the RAM port in the current cycle.
//   hs_wr_pack()          : builds an hs_wr_t from separate address/data.
package hiscore_pkg;

    localparam int HS_ADDR_W = 12;
    localparam int HS_DATA_W = 8;

    typedef struct packed {
        logic [HS_ADDR_W-1:0] addr;
        logic [HS_DATA_W-1:0] data;
    } hs_wr_t;

    typedef enum logic [1:0] {
        GRANT_CPU = 2'd0,
        GRANT_WR  = 2'd1,
        GRANT_RD  = 2'd2
    } hs_grant_e;

    function automatic hs_wr_t hs_wr_pack(
        input logic [HS_ADDR_W-1:0] addr,
        input logic [HS_DATA_W-1:0] data
    );
        hs_wr_t entry;
        entry.addr = addr;
        entry.data = data;
        return entry;
    endfunction

endpackage

// File: rtl/hs_wr_fifo.sv
// hs_wr_fifo
// Synchronous write buffer for engine writes, first-word-fall-through head.
// A push while full is accepted only if a pop happens in the same cycle
// (the freed slot is reused); otherwise the push is ignored here and the
// caller flags the drop.
//   clk, reset : clock, asynchronous active-high reset (flushes the buffer)
//   push_i     : write din_i at the tail
//   pop_i      : discard the head (ignored while empty)
//   din_i      : entry to push
//   head_o     : oldest entry, valid whenever empty_o = 0
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : number of entries held
module hs_wr_fifo
    import hiscore_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  hs_wr_t                 din_i,
    output hs_wr_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    hs_wr_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             pop_s;
    logic             push_s;

    // Qualified push/pop and next pointer/count values.
    always_comb begin
        pop_s  = pop_i && (cnt_q != {(PTR_W + 1){1'b0}});
        push_s = push_i && ((cnt_q != CNT_MAX) || pop_s);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {(PTR_W + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CNT_MAX);
    assign empty_o = (cnt_q == {(PTR_W + 1){1'b0}});
    assign count_o = cnt_q;

endmodule

// File: rtl/hiscore_ram_port.sv
// hiscore_ram_port
// Shares the Pac-Man work RAM between the CPU and the high-score engine.
// Engine writes are buffered and drained in cycles the CPU leaves free;
// engine reads use the remaining free cycles. If buffered writes wait too
// long (or an upload is running) the CPU is asked to pause.
//   clk, reset          : clock, asynchronous active-high reset
//   hs_address/hs_data  : engine address (reads and writes) / write data
//   hs_write            : one write request per high cycle
//   ioctl_upload        : upload in progress, forces cpu_pause
//   hs_din/hs_din_valid : engine read data and its one-cycle update pulse
//   cpu_cs/we/addr/wdata: CPU RAM access, highest priority
//   cpu_rdata           : RAM read data passed straight to the CPU
//   cpu_pause           : CPU clock-enable hold request
//   ram_addr/din/we     : work-RAM port
//   ram_dout            : work-RAM read data (one-cycle latency)
//   overflow            : sticky, an engine write was dropped
module hiscore_ram_port
    import hiscore_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] hs_address,
    input  logic [DATA_W-1:0] hs_data,
    input  logic              hs_write,
    input  logic              ioctl_upload,
    output logic [DATA_W-1:0] hs_din,
    output logic              hs_din_valid,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_pause,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);
    localparam logic [ST_W-1:0]  ST_ONE     = ST_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    hs_grant_e         grant_s;
    hs_wr_t            push_entry_s;
    hs_wr_t            head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_cnt_s;
    logic [CNT_W-1:0]  fifo_cnt_next_s;
    logic              pop_s;
    logic              push_acc_s;
    logic              drop_s;

    logic [ST_W-1:0]   starve_q, starve_d;
    logic              pause_q, pause_d;
    logic              ovf_q, ovf_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              din_vld_q, din_vld_d;

    assign push_entry_s = hs_wr_pack(hs_address, hs_data);

    hs_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (hs_write),
        .pop_i   (pop_s),
        .din_i   (push_entry_s),
        .head_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_cnt_s)
    );

    // Slot owner for this cycle: CPU, then buffered write, then engine read.
    always_comb begin
        if (cpu_cs) begin
            grant_s = GRANT_CPU;
        end else if (!fifo_empty_s) begin
            grant_s = GRANT_WR;
        end else begin
            grant_s = GRANT_RD;
        end
    end

    // RAM port mux; CPU goes straight through with no added latency.
    always_comb begin
        case (grant_s)
            GRANT_CPU: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_wdata;
                ram_we   = cpu_we;
            end
            GRANT_WR: begin
                ram_addr = head_s.addr;
                ram_din  = head_s.data;
                ram_we   = 1'b1;
            end
            GRANT_RD: begin
                ram_addr = hs_address;
                ram_din  = hs_data;
                ram_we   = 1'b0;
            end
            default: begin
                ram_addr = hs_address;
                ram_din  = hs_data;
                ram_we   = 1'b0;
            end
        endcase
    end

    // Buffer bookkeeping: a full buffer still takes a push if it pops too.
    always_comb begin
        pop_s      = (grant_s == GRANT_WR);
        push_acc_s = hs_write && (!fifo_full_s || pop_s);
        drop_s     = hs_write && fifo_full_s && !pop_s;

        case ({push_acc_s, pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_s + CNT_ONE;
            2'b01:   fifo_cnt_next_s = fifo_cnt_s - CNT_ONE;
            default: fifo_cnt_next_s = fifo_cnt_s;
        endcase
    end

    // Starve counter, pause request and sticky overflow.
    always_comb begin
        if (fifo_empty_s || pop_s) begin
            starve_d = {ST_W{1'b0}};
        end else if (starve_q == STARVE_MAX) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + ST_ONE;
        end

        // Pause is released only once the buffer will be empty after this
        // edge, so the CPU stays held until every queued write has landed.
        if ((starve_d == STARVE_MAX) || ioctl_upload) begin
            pause_d = 1'b1;
        end else if (fifo_cnt_next_s == {CNT_W{1'b0}}) begin
            pause_d = 1'b0;
        end else begin
            pause_d = pause_q;
        end

        ovf_d = ovf_q | drop_s;
    end

    // Engine read pipeline: grant cycle, RAM latency cycle, then capture.
    always_comb begin
        rd_pend_d = (grant_s == GRANT_RD);
        if (rd_pend_q) begin
            din_d     = ram_dout;
            din_vld_d = 1'b1;
        end else begin
            din_d     = din_q;
            din_vld_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q  <= {ST_W{1'b0}};
            pause_q   <= 1'b0;
            ovf_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            din_q     <= {DATA_W{1'b0}};
            din_vld_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            pause_q   <= pause_d;
            ovf_q     <= ovf_d;
            rd_pend_q <= rd_pend_d;
            din_q     <= din_d;
            din_vld_q <= din_vld_d;
        end
    end

    assign hs_din       = din_q;
    assign hs_din_valid = din_vld_q;
    assign cpu_pause    = pause_q;
    assign overflow     = ovf_q;
    assign cpu_rdata    = ram_dout;

endmodule

// File: doc/hiscore_ram_port.md
# hiscore_ram_port

Arbitrating port between the high-score engine and the Pac-Man 4 KB work RAM. It buffers the engine's single-cycle write pulses in a small FIFO and drains them only in cycles the CPU is not using the RAM. It serves the engine's validate/upload reads in the same idle slots and stalls the CPU when buffered writes starve. It sits directly downstream of the high-score engine's `ram_address`/`data_to_ram`/`ram_write` outputs and upstream of the work-RAM port and `ioctl_din`.

## Interface

Parameters:
- `ADDR_W`, 12: RAM address width.
- `DATA_W`, 8: RAM data width.
- `FIFO_DEPTH`, 4: write-buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, 64: cycles a non-empty FIFO may go undrained before CPU pause.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `hs_address` in `ADDR_W`: engine address, used for both reads and writes.
- `hs_data` in `DATA_W`: engine write data.
- `hs_write` in 1: each high cycle is one write request.
- `ioctl_upload` in 1: upload in progress.
- `hs_din` out `DATA_W`: last RAM byte read for the engine; feeds `ioctl_din`.
- `hs_din_valid` out 1: one-cycle pulse when `hs_din` updates.
- `cpu_cs` in 1: CPU RAM select.
- `cpu_we` in 1: CPU write strobe, qualified by `cpu_cs`.
- `cpu_addr` in `ADDR_W`: CPU address.
- `cpu_wdata` in `DATA_W`: CPU write data.
- `cpu_rdata` out `DATA_W`: equals `ram_dout`, combinational passthrough.
- `cpu_pause` out 1: CPU clock-enable hold request.
- `ram_addr` out `ADDR_W`: work-RAM address.
- `ram_din` out `DATA_W`: work-RAM write data.
- `ram_we` out 1: work-RAM write enable.
- `ram_dout` in `DATA_W`: work-RAM read data, one-cycle synchronous latency.
- `overflow` out 1: sticky flag, a write was dropped.

## Operation

Slot grant is decided combinationally every cycle, in priority order:
1. CPU: when `cpu_cs`=1. RAM port = `cpu_addr`/`cpu_wdata`; `ram_we` = `cpu_we`.
2. FIFO drain: when `cpu_cs`=0 and FIFO is non-empty. RAM port = head entry; `ram_we`=1; head pops at the clock edge.
3. Engine read: otherwise. `ram_addr` = `hs_address`; `ram_we`=0.

FIFO rules:
- Push `{hs_address, hs_data}` on every `hs_write`=1 cycle.
- Simultaneous push and pop is legal at any fill level, including full; count is unchanged.
- Push when full with no pop: drop the entry and set `overflow`. `overflow` clears only on reset.
- Entries drain in order; no write coalescing.

Starve counter:
- Counts cycles in which the FIFO is non-empty and no pop occurs.
- Clears on any pop or when the FIFO is empty.
- Saturates at `STARVE_LIMIT`.

`cpu_pause` (registered):
- Set when the starve counter reaches `STARVE_LIMIT`, or while `ioctl_upload`=1.
- Clears the cycle after the FIFO becomes empty while `ioctl_upload`=0.
- The CPU deasserts `cpu_cs` while paused, which frees slots for the FIFO.

Read return:
- An engine-read grant in cycle N captures `ram_dout` at the end of N+1.
- `hs_din` and `hs_din_valid` are visible in N+2.
- With no engine-read grant, `hs_din` holds its value.

## Timing

- Reset values: `hs_din`=0, `hs_din_valid`=0, `cpu_pause`=0, `overflow`=0, FIFO empty, starve counter 0. With `cpu_cs`=0 the port is therefore in engine-read mode with `ram_we`=0.
- CPU path: zero added latency; the address reaches the RAM in the same cycle.
- Write latency: `hs_write` in cycle N reaches the RAM no earlier than N+1.
- Read latency: exactly 2 cycles from grant to `hs_din_valid`.
- Pause: `cpu_pause` rises one cycle after the counter reaches `STARVE_LIMIT`.
- Reset mid-operation: FIFO flushed, pending writes lost, pause released immediately, read pipeline cleared with no `hs_din_valid` pulse.
- `hs_write` during reset is ignored.

## Structure

- Package `hiscore_pkg`: `HS_ADDR_W`=12, `HS_DATA_W`=8, typedef `hs_wr_t` (packed struct of addr and data), and an enum `hs_grant_e` with values `GRANT_CPU`, `GRANT_WR`, `GRANT_RD`.
- Sub-module `hs_wr_fifo`: synchronous FIFO of `hs_wr_t` with push/pop/full/empty/count, first-word-fall-through head, asynchronous reset.
- Top level holds grant logic, starve counter, pause register and read pipeline.

## Test plan

- Idle CPU: `hs_write` pulse addr 0x0B0, data 0x5A → `ram_we`=1 with `ram_addr`=0x0B0, `ram_din`=0x5A one cycle later; FIFO empty afterwards.
- CPU busy: `cpu_cs`=1 held for 10 cycles, 3 engine writes pushed → no FIFO write during the busy period; the 3 writes drain in order in the 3 cycles after `cpu_cs` falls.
- Starvation: `cpu_cs`=1 held continuously with 1 entry queued → `cpu_pause`=1 on cycle 65 after the push; CPU drops `cs`, entry drains, `cpu_pause`=0 the next cycle.
- Overflow: 5 pushes while `cpu_cs`=1 → 4 entries retained, `overflow`=1; a push while full coinciding with a pop is accepted and `overflow` stays 0 (separate run).
- Read: RAM 0x023 holds 0x0F, engine reads 0x023 with `cpu_cs`=0 → `hs_din`=0x0F and `hs_din_valid` pulse at N+2; a CPU grant in N produces no pulse.
- Reset: assert `reset` with 3 entries queued and pause active → all outputs at reset values; no write reaches the RAM after release.
